// File: rtl/alu_cargador_operandos_if.sv
// ---------------------------------------------------------------------------
// alu_cargador_operandos_if
// Purpose : bundles the board-side and ALU-side signals of the ALU operand
//           loader so the loader and its surroundings connect through one port.
// Signals :
//   interruptores  n  operand switches, active-high          (board -> loader)
//   codigo         4  opcode switches, active-low on board   (board -> loader)
//   boton          1  load/advance button, active-low, async (board -> loader)
//   resultado_alu  4  ALU result, combinational              (ALU   -> loader)
//   flags_alu      4  {carry, cero, negativo, desbordamiento}(ALU   -> loader)
//   entrada1       n  registered operand 1                   (loader -> ALU)
//   entrada2       n  registered operand 2                   (loader -> ALU)
//   selector       4  registered opcode, already inverted    (loader -> ALU)
//   resultado      4  latched result for the display         (loader -> board)
//   flags          4  latched flags, same order as flags_alu (loader -> board)
//   etapa          4  one-hot stage LEDs {MUESTRA, OP, B, A} (loader -> board)
//   listo          1  latched result valid                   (loader -> board)
//   estado_dbg     3  raw FSM state, for observation only    (loader -> any)
// Handshake: there is no valid/ready pair on this bus. The only event is the
// debounced button press; the loader samples the switches on that single
// cycle and every output is a plain register that holds until the next event.
// Modports: slave = the loader, master = the board/ALU side driving it.
// ---------------------------------------------------------------------------
interface alu_cargador_operandos_if #(
    parameter int n = 4
);
    logic [n-1:0] interruptores;
    logic [3:0]   codigo;
    logic         boton;
    logic [3:0]   resultado_alu;
    logic [3:0]   flags_alu;
    logic [n-1:0] entrada1;
    logic [n-1:0] entrada2;
    logic [3:0]   selector;
    logic [3:0]   resultado;
    logic [3:0]   flags;
    logic [3:0]   etapa;
    logic         listo;
    logic [2:0]   estado_dbg;

    modport slave (
        input  interruptores, codigo, boton, resultado_alu, flags_alu,
        output entrada1, entrada2, selector, resultado, flags, etapa, listo,
               estado_dbg
    );

    modport master (
        output interruptores, codigo, boton, resultado_alu, flags_alu,
        input  entrada1, entrada2, selector, resultado, flags, etapa, listo,
               estado_dbg
    );
endinterface

// File: rtl/alu_cargador_operandos.sv
// ---------------------------------------------------------------------------
// alu_cargador_operandos
// Purpose : input side of the board ALU. A debounced push-button steps a
//           sequenced load of operand 1, operand 2 and the opcode from the
//           switches, lets the ALU settle for one cycle, then latches the
//           result and flags for the 7-segment decoders.
// Ports   :
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   bus    alu_cargador_operandos_if.slave (switches, button, ALU result and
//          flags in; operands, opcode, latched result/flags, stage LEDs,
//          listo and a debug copy of the FSM state out)
// Parameters: n (operand width), DEBOUNCE_CYCLES, TIMEOUT_CYCLES.
// Build option: define ALU_CARGADOR_TIMEOUT_EN to abandon a load that sits
//           idle in CARGA_B/CARGA_OP for TIMEOUT_CYCLES cycles. Without it the
//           FSM waits indefinitely. Ports are the same in both builds.
// ---------------------------------------------------------------------------
module alu_cargador_operandos #(
    parameter int n               = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input logic                     clk,
    input logic                     reset,
    alu_cargador_operandos_if.slave bus
);

    localparam logic [2:0] CARGA_A  = 3'd0;
    localparam logic [2:0] CARGA_B  = 3'd1;
    localparam logic [2:0] CARGA_OP = 3'd2;
    localparam logic [2:0] EJECUTA  = 3'd3;
    localparam logic [2:0] MUESTRA  = 3'd4;

    localparam int             DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

    // ---------------- button synchroniser and debouncer ----------------
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          pulsar_q, pulsar_d;
    logic [1:0]    vivo_q, vivo_d;
    logic          armado_q, armado_d;

    always_comb begin
        sync1_d   = bus.boton;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        pulsar_d  = 1'b0;
        vivo_d    = {vivo_q[0], 1'b1};
        // The synchroniser holds its reset value (released) for two cycles,
        // so only a released level seen after it carries real samples arms
        // the press detector. A button held through reset therefore has to
        // be released before it can produce a press.
        armado_d  = armado_q | (vivo_q[1] & deb_q & sync2_q);
        if (sync2_q == deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
            deb_d     = sync2_q;
            deb_cnt_d = '0;
            pulsar_d  = deb_q & ~sync2_q & armado_q;
        end else if (deb_cnt_q != '1) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
            pulsar_q  <= 1'b0;
            vivo_q    <= 2'b00;
            armado_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            pulsar_q  <= pulsar_d;
            vivo_q    <= vivo_d;
            armado_q  <= armado_d;
        end
    end

    // ---------------- load FSM ----------------
    logic [2:0]   estado_q, estado_d;
    logic [n-1:0] entrada1_q, entrada1_d, entrada2_q, entrada2_d;
    logic [3:0]   selector_q, selector_d;
    logic [3:0]   resultado_q, resultado_d, flags_q, flags_d;
    logic         listo_q, listo_d;
    logic         timeout_hit;

`ifdef ALU_CARGADOR_TIMEOUT_EN
    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          esperando;

    assign esperando   = (estado_q == CARGA_B) || (estado_q == CARGA_OP);
    assign timeout_hit = esperando && (to_cnt_q == TO_MAX);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!esperando || pulsar_q || timeout_hit) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        estado_d    = estado_q;
        entrada1_d  = entrada1_q;
        entrada2_d  = entrada2_q;
        selector_d  = selector_q;
        resultado_d = resultado_q;
        flags_d     = flags_q;
        listo_d     = listo_q;
        case (estado_q)
            CARGA_A: begin
                if (pulsar_q) begin
                    entrada1_d = bus.interruptores;
                    estado_d   = CARGA_B;
                end
            end
            CARGA_B: begin
                // A press on the timeout cycle wins: the load happens.
                if (pulsar_q) begin
                    entrada2_d = bus.interruptores;
                    estado_d   = CARGA_OP;
                end else if (timeout_hit) begin
                    estado_d   = CARGA_A;
                end
            end
            CARGA_OP: begin
                if (pulsar_q) begin
                    selector_d = ~bus.codigo;
                    estado_d   = EJECUTA;
                end else if (timeout_hit) begin
                    estado_d   = CARGA_A;
                end
            end
            EJECUTA: begin
                // One settle cycle for the combinational ALU; presses here
                // are dropped rather than queued.
                resultado_d = bus.resultado_alu;
                flags_d     = bus.flags_alu;
                listo_d     = 1'b1;
                estado_d    = MUESTRA;
            end
            MUESTRA: begin
                if (pulsar_q) begin
                    listo_d  = 1'b0;
                    estado_d = CARGA_A;
                end
            end
            default: estado_d = CARGA_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= CARGA_A;
            entrada1_q  <= '0;
            entrada2_q  <= '0;
            selector_q  <= 4'b0000;
            resultado_q <= 4'b0000;
            flags_q     <= 4'b0000;
            listo_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            entrada1_q  <= entrada1_d;
            entrada2_q  <= entrada2_d;
            selector_q  <= selector_d;
            resultado_q <= resultado_d;
            flags_q     <= flags_d;
            listo_q     <= listo_d;
        end
    end

    logic [3:0] etapa;

    always_comb begin
        case (estado_q)
            CARGA_A:          etapa = 4'b0001;
            CARGA_B:          etapa = 4'b0010;
            CARGA_OP:         etapa = 4'b0100;
            EJECUTA, MUESTRA: etapa = 4'b1000;
            default:          etapa = 4'b0001;
        endcase
    end

    assign bus.entrada1   = entrada1_q;
    assign bus.entrada2   = entrada2_q;
    assign bus.selector   = selector_q;
    assign bus.resultado  = resultado_q;
    assign bus.flags      = flags_q;
    assign bus.etapa      = etapa;
    assign bus.listo      = listo_q;
    assign bus.estado_dbg = estado_q;

endmodule

// File: tb/tb_alu_cargador_operandos.sv
// ---------------------------------------------------------------------------
// tb_alu_cargador_operandos
// Directed bench for the ALU operand loader with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=50. A small ALU model (add for opcode 0001, subtract for
// 0010) drives resultado_alu/flags_alu from the loader's outputs; expected
// values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_cargador_operandos;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    alu_cargador_operandos_if #(.n(4)) bus ();

    alu_cargador_operandos #(
        .n              (4),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    logic [3:0] alu_b;
    logic [4:0] alu_s;

    always_comb begin
        alu_b = bus.entrada2;
        alu_s = {1'b0, bus.entrada1} + {1'b0, bus.entrada2};
        if (bus.selector == 4'b0010) begin
            alu_b = ~bus.entrada2;
            alu_s = {1'b0, bus.entrada1} + {1'b0, alu_b} + 5'd1;
        end
        bus.resultado_alu = alu_s[3:0];
        bus.flags_alu     = {alu_s[4], (alu_s[3:0] == 4'd0), alu_s[3],
                             (bus.entrada1[3] == alu_b[3]) && (alu_s[3] != bus.entrada1[3])};
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] sw);
        bus.interruptores = sw;
        bus.boton = 1'b0;
        tick(10);
        bus.boton = 1'b1;
        tick(10);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset             = 1'b1;
        bus.boton         = 1'b1;
        bus.interruptores = 4'h0;
        bus.codigo        = 4'b1111;
        tick(3);

        // Reset values
        check("rst_entrada1", bus.entrada1, 4'h0);
        check("rst_entrada2", bus.entrada2, 4'h0);
        check("rst_selector", bus.selector, 4'b0000);
        check("rst_resultado", bus.resultado, 4'h0);
        check("rst_flags", bus.flags, 4'h0);
        check("rst_listo", bus.listo, 1'b0);
        check("rst_etapa", bus.etapa, 4'b0001);
        reset = 1'b0;
        tick(5);

        // Clean load: 3 + 5 with opcode ~1110 = 0001 (add)
        press(4'h3);
        check("a_entrada1", bus.entrada1, 4'h3);
        check("a_etapa", bus.etapa, 4'b0010);
        press(4'h5);
        check("b_entrada2", bus.entrada2, 4'h5);
        check("b_etapa", bus.etapa, 4'b0100);
        bus.codigo = 4'b1110;
        bus.boton  = 1'b0;
        tick(6);
        check("op_before_pulse", bus.etapa, 4'b0100);
        tick(1);
        check("op_selector", bus.selector, 4'b0001);
        check("ejecuta_etapa", bus.etapa, 4'b1000);
        check("ejecuta_listo", bus.listo, 1'b0);
        tick(1);
        check("muestra_listo", bus.listo, 1'b1);
        check("muestra_resultado", bus.resultado, 4'h8);
        check("muestra_flags", bus.flags, 4'b0011);
        check("muestra_etapa", bus.etapa, 4'b1000);
        bus.boton = 1'b1;
        tick(10);

        // Switch changes while showing the result have no effect
        bus.interruptores = 4'($urandom_range(15, 10));
        bus.codigo        = 4'b0000;
        tick(20);
        check("hold_entrada1", bus.entrada1, 4'h3);
        check("hold_entrada2", bus.entrada2, 4'h5);
        check("hold_selector", bus.selector, 4'b0001);
        check("hold_resultado", bus.resultado, 4'h8);
        check("hold_flags", bus.flags, 4'b0011);
        press(4'hA);
        check("back_listo", bus.listo, 1'b0);
        check("back_etapa", bus.etapa, 4'b0001);
        check("back_entrada1", bus.entrada1, 4'h3);
        check("back_entrada2", bus.entrada2, 4'h5);

        // Bounce: toggle every 2 cycles for 20 cycles, then stay low
        bus.interruptores = 4'h9;
        for (int i = 0; i < 10; i++) begin
            bus.boton = ~bus.boton;
            tick(2);
        end
        check("bounce_no_early", bus.etapa, 4'b0001);
        bus.boton = 1'b0;
        tick(6);
        check("bounce_before_pulse", bus.etapa, 4'b0001);
        tick(1);
        check("bounce_after_pulse", bus.etapa, 4'b0010);
        check("bounce_entrada1", bus.entrada1, 4'h9);
        tick(10);
        check("bounce_single", bus.etapa, 4'b0010);
        bus.boton = 1'b1;
        tick(10);

        // Held press: 100 cycles low loads only once
        bus.interruptores = 4'h6;
        bus.boton = 1'b0;
        tick(100);
        check("held_etapa", bus.etapa, 4'b0100);
        check("held_entrada2", bus.entrada2, 4'h6);
        bus.boton = 1'b1;
        tick(10);
        check("held_release", bus.etapa, 4'b0100);
        bus.codigo = 4'b1101;
        press(4'h0);
        check("sub_selector", bus.selector, 4'b0010);
        check("sub_resultado", bus.resultado, 4'h3);
        check("sub_flags", bus.flags, 4'b1001);
        check("sub_listo", bus.listo, 1'b1);
        press(4'h0);
        check("sub_back_etapa", bus.etapa, 4'b0001);

        // Reset mid-load with the button held through reset
        press(4'h7);
        press(4'h2);
        check("mid_entrada1", bus.entrada1, 4'h7);
        check("mid_etapa", bus.etapa, 4'b0100);
        bus.boton = 1'b0;
        reset = 1'b1;
        tick(1);
        check("midrst_entrada1", bus.entrada1, 4'h0);
        check("midrst_entrada2", bus.entrada2, 4'h0);
        check("midrst_etapa", bus.etapa, 4'b0001);
        check("midrst_listo", bus.listo, 1'b0);
        reset = 1'b0;
        tick(30);
        check("held_rst_no_pulse", bus.etapa, 4'b0001);
        bus.boton = 1'b1;
        tick(10);
        check("held_rst_release", bus.etapa, 4'b0001);
        press(4'h4);
        check("after_rst_entrada1", bus.entrada1, 4'h4);
        check("after_rst_etapa", bus.etapa, 4'b0010);

        // Idle in CARGA_B
`ifdef ALU_CARGADOR_TIMEOUT_EN
        tick(40);
        check("timeout_etapa", bus.etapa, 4'b0001);
        check("timeout_entrada1", bus.entrada1, 4'h4);
        check("timeout_listo", bus.listo, 1'b0);
`else
        tick(200);
        check("no_timeout_etapa", bus.etapa, 4'b0010);
        check("no_timeout_entrada1", bus.entrada1, 4'h4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
